regfile_param: RTL and testbench
================================

Name: regfile_param

Overview:
- Parametrised successor to the fixed 32x32 register bank.
- Generic DEPTH x DATA_W register file with:
  - one write port;
  - two registered read ports with write-first bypass;
  - optional hardwired-zero register 0;
  - sequenced bulk-clear engine.
- Sits between the datapath write-back stage and the operand-fetch stage of the processor core.

Parameters:
- DATA_W, 32, width of each register in bits
- DEPTH, 32, number of registers; power of two, minimum 2
- ADDR_W, 5, address width; must equal log2(DEPTH)
- ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes; 0 = register 0 is ordinary

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- regwrite  in  1  write enable, sampled at clk rise
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rd_addr_a  in  ADDR_W  read port A address
- rd_addr_b  in  ADDR_W  read port B address
- rd_data_a  out  DATA_W  registered read data, port A
- rd_data_b  out  DATA_W  registered read data, port B
- clr_req  in  1  single-cycle pulse that starts a bulk clear
- busy  out  1  high while the clear engine runs
- wr_drop  out  1  registered pulse: a write was rejected because busy was high

Behaviour:
- Clock and reset
  - Single clock domain.
  - rst is synchronous, active-high, sampled on clk rise; it overrides every other input.
- Reset state
  - All DEPTH registers = 0.
  - rd_data_a = rd_data_b = 0.
  - busy = 0, wr_drop = 0, FSM = IDLE, clear index = 0.
- Write
  - On clk rise with regwrite=1 and busy=0, reg[wr_addr] <= wr_data.
  - With ZERO_REG=1, a write to addr 0 is silently ignored and does not assert wr_drop.
- Read (latency 1)
  - rd_data_x <= reg[rd_addr_x] on every clk rise.
  - Write-first bypass: if the same edge performs a real write to rd_addr_x, rd_data_x <= wr_data.
  - No bypass when the write is suppressed (ZERO_REG addr 0, or busy).
  - With ZERO_REG=1 and rd_addr_x=0, rd_data_x <= 0 unconditionally.
  - Both ports may read the same address in the same cycle.
- Clear FSM: states IDLE, CLEAR
  - IDLE -> CLEAR: on clr_req=1. The index loads 0 and busy rises on the next edge.
  - CLEAR: each cycle, reg[index] <= 0 and index <= index+1.
  - CLEAR -> IDLE: on the edge that clears index DEPTH-1; busy falls on that same edge.
  - Clear duration is exactly DEPTH cycles of busy=1.
  - clr_req while in CLEAR is ignored; no restart, no queueing.
  - regwrite with clr_req in the same IDLE cycle: the write is performed, then the clear starts and erases it.
- Behaviour while busy
  - Writes are dropped; wr_drop=1 on the following cycle, for one cycle per dropped write.
  - Reads continue. They return current array contents: registers already swept read 0, the rest keep their old values.
  - A read of the address being cleared on this edge returns 0 (clear-first bypass).
- rst mid-clear: immediate return to IDLE with all registers 0 and busy=0 on that edge.
- Index wrap: the index is ADDR_W bits wide; termination is detected by comparing against DEPTH-1, not by overflow.
- Outputs are all registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset, then write 0xDEADBEEF to addr 5; the next cycle read A=5 -> rd_data_a=0xDEADBEEF one cycle after the read address is presented; B=6 -> 0.
- ZERO_REG=1: write 0x12345678 to addr 0, read A=0 same cycle and next -> 0 both times; wr_drop stays 0.
- Bypass: regwrite with addr 9 data 0xA5A5A5A5 while rd_addr_a=rd_addr_b=9 (old value 0x1) -> both outputs 0xA5A5A5A5 after 1 cycle.
- Clear: fill regs 1..31 with their index, pulse clr_req -> busy high exactly 32 cycles. A write of 0x77 to addr 3 at cycle 10 of busy -> wr_drop pulse next cycle; after busy falls, all reads return 0.
- Mid-clear reads: during CLEAR, read addr 30 at sweep index 4 -> 30; read addr 2 -> 0.
- rst asserted at sweep index 12 -> busy=0 next cycle, all regs read 0; a new clr_req afterwards runs a full 32 cycles.

Source files
------------

// File: rtl/regfile_param.sv
// DEPTH x DATA_W register file: one write port, two registered read ports with
// write-first bypass, optional hardwired-zero register 0 and a sequenced bulk clear.
module regfile_param #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              regwrite,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              clr_req,
  output logic              busy,
  output logic              wr_drop
);

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);
  localparam bit                HasZero = (ZERO_REG != 0);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              busy_q, busy_d;
  logic              wr_drop_q, wr_drop_d;
  logic [DATA_W-1:0] rd_a_q, rd_a_d;
  logic [DATA_W-1:0] rd_b_q, rd_b_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic zero_wr;
  logic wr_en;
  logic clr_en;

  // Writes to the hardwired zero register are discarded without a drop pulse.
  assign zero_wr = HasZero && (wr_addr == '0);
  assign wr_en   = regwrite && !busy_q && !zero_wr;
  assign clr_en  = (state_q == CLEAR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Sweep terminates on an explicit compare, never on index overflow.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          idx_d   = '0;
        end
      end
      CLEAR: begin
        idx_d = idx_q + ADDR_W'(1);
        if (idx_q == LastIdx) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read data reflects the array as it stands after this edge's write or clear.
  always_comb begin
    busy_d    = (state_d == CLEAR);
    wr_drop_d = regwrite && busy_q && !zero_wr;

    rd_a_d = mem_q[rd_addr_a];
    if (wr_en && (wr_addr == rd_addr_a)) rd_a_d = wr_data;
    if (clr_en && (idx_q == rd_addr_a)) rd_a_d = '0;
    if (HasZero && (rd_addr_a == '0)) rd_a_d = '0;

    rd_b_d = mem_q[rd_addr_b];
    if (wr_en && (wr_addr == rd_addr_b)) rd_b_d = wr_data;
    if (clr_en && (idx_q == rd_addr_b)) rd_b_d = '0;
    if (HasZero && (rd_addr_b == '0)) rd_b_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (wr_en) mem_q[wr_addr] <= wr_data;
      if (clr_en) mem_q[idx_q] <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q    <= 1'b0;
      wr_drop_q <= 1'b0;
      rd_a_q    <= '0;
      rd_b_q    <= '0;
    end else begin
      busy_q    <= busy_d;
      wr_drop_q <= wr_drop_d;
      rd_a_q    <= rd_a_d;
      rd_b_q    <= rd_b_d;
    end
  end

  assign rd_data_a = rd_a_q;
  assign rd_data_b = rd_b_q;
  assign busy      = busy_q;
  assign wr_drop   = wr_drop_q;

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: directed scenarios plus randomized traffic
// compared against an array-based reference model.
module tb_regfile_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        regwrite;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr_a;
  logic [4:0]  rd_addr_b;
  logic [31:0] rd_data_a;
  logic [31:0] rd_data_b;
  logic        clr_req;
  logic        busy;
  logic        wr_drop;

  int total = 0;
  int bad   = 0;

  // Reference model: register contents, clear progress, expected outputs.
  logic [31:0] m_mem [32];
  bit          m_busy;
  int          m_cnt;
  logic [31:0] e_a, e_b;
  logic        e_drop;

  always #5 clk = ~clk;

  regfile_param #(
    .DATA_W(32), .DEPTH(32), .ADDR_W(5), .ZERO_REG(1)
  ) dut (
    .clk(clk), .rst(rst), .regwrite(regwrite), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rd_data_a),
    .rd_data_b(rd_data_b), .clr_req(clr_req), .busy(busy), .wr_drop(wr_drop)
  );

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra, input logic [4:0] rb, input logic clr);
    regwrite  = we;
    wr_addr   = wa;
    wr_data   = wd;
    rd_addr_a = ra;
    rd_addr_b = rb;
    clr_req   = clr;
  endtask

  // Advance model and DUT by one edge; reads see the contents after the edge's update.
  task automatic cycle();
    if (rst) begin
      for (int i = 0; i < 32; i++) m_mem[i] = '0;
      m_busy = 0;
      m_cnt  = 0;
      e_a    = '0;
      e_b    = '0;
      e_drop = 1'b0;
    end else begin
      e_drop = regwrite && m_busy && (wr_addr != 5'd0);
      if (m_busy) begin
        m_mem[m_cnt] = '0;
        m_cnt++;
        if (m_cnt == 32) m_busy = 0;
      end else begin
        if (regwrite && wr_addr != 5'd0) m_mem[wr_addr] = wr_data;
        if (clr_req) begin
          m_busy = 1;
          m_cnt  = 0;
        end
      end
      e_a = m_mem[rd_addr_a];
      e_b = m_mem[rd_addr_b];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fill();
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, 5'(i), 32'(i), 5'd0, 5'd0, 1'b0);
      cycle();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 5'd5, 32'hFFFF_FFFF, 5'd5, 5'd5, 1'b1);
    cycle();
    cycle();
    total++; if (rd_data_a !== 32'd0) begin bad++; $display("FAIL reset_rd_a got=%h exp=0", rd_data_a); end
    total++; if (rd_data_b !== 32'd0) begin bad++; $display("FAIL reset_rd_b got=%h exp=0", rd_data_b); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (wr_drop !== 1'b0) begin bad++; $display("FAIL reset_wr_drop got=%b exp=0", wr_drop); end
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i), 1'b0);
      cycle();
      total++;
      if (rd_data_a !== 32'd0 || rd_data_b !== 32'd0) begin
        bad++;
        $display("FAIL reset_contents addr=%0d got_a=%h got_b=%h exp=0", i, rd_data_a, rd_data_b);
      end
    end
  endtask

  task automatic test_write_read();
    drive(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd0, 5'd0, 1'b0);
    cycle();
    drive(1'b0, 5'd0, 32'd0, 5'd5, 5'd6, 1'b0);
    cycle();
    total++; if (rd_data_a !== 32'hDEAD_BEEF) begin bad++; $display("FAIL write_read_a got=%h exp=deadbeef", rd_data_a); end
    total++; if (rd_data_b !== 32'd0) begin bad++; $display("FAIL write_read_b got=%h exp=0", rd_data_b); end
  endtask

  task automatic test_zero_reg();
    drive(1'b1, 5'd0, 32'h1234_5678, 5'd0, 5'd0, 1'b0);
    cycle();
    total++; if (rd_data_a !== 32'd0) begin bad++; $display("FAIL zero_same_cycle got=%h exp=0", rd_data_a); end
    total++; if (wr_drop !== 1'b0) begin bad++; $display("FAIL zero_wr_drop got=%b exp=0", wr_drop); end
    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0);
    cycle();
    total++; if (rd_data_a !== 32'd0) begin bad++; $display("FAIL zero_next_cycle got=%h exp=0", rd_data_a); end
    total++; if (wr_drop !== 1'b0) begin bad++; $display("FAIL zero_wr_drop2 got=%b exp=0", wr_drop); end
  endtask

  task automatic test_bypass();
    drive(1'b1, 5'd9, 32'h0000_0001, 5'd0, 5'd0, 1'b0);
    cycle();
    drive(1'b1, 5'd9, 32'hA5A5_A5A5, 5'd9, 5'd9, 1'b0);
    cycle();
    total++; if (rd_data_a !== 32'hA5A5_A5A5) begin bad++; $display("FAIL bypass_a got=%h exp=a5a5a5a5", rd_data_a); end
    total++; if (rd_data_b !== 32'hA5A5_A5A5) begin bad++; $display("FAIL bypass_b got=%h exp=a5a5a5a5", rd_data_b); end
  endtask

  task automatic test_clear();
    int k;
    fill();
    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1);
    cycle();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL clear_start_busy got=%b exp=1", busy); end
    k = 0;
    while (busy === 1'b1 && k < 40) begin
      if (k == 4) drive(1'b0, 5'd0, 32'd0, 5'd30, 5'd2, 1'b0);
      else if (k == 10) drive(1'b1, 5'd3, 32'h77, 5'd3, 5'd29, 1'b0);
      else if (k == 20) drive(1'b0, 5'd0, 32'd0, 5'd20, 5'd21, 1'b1);
      else drive(1'b0, 5'd0, 32'd0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'b0);
      cycle();
      total++;
      if (rd_data_a !== e_a || rd_data_b !== e_b) begin
        bad++;
        $display("FAIL clear_read k=%0d got_a=%h exp_a=%h got_b=%h exp_b=%h", k, rd_data_a, e_a, rd_data_b, e_b);
      end
      total++; if (wr_drop !== e_drop) begin bad++; $display("FAIL clear_wr_drop k=%0d got=%b exp=%b", k, wr_drop, e_drop); end
      if (k == 4) begin
        total++; if (rd_data_a !== 32'd30) begin bad++; $display("FAIL clear_unswept got=%h exp=1e", rd_data_a); end
        total++; if (rd_data_b !== 32'd0) begin bad++; $display("FAIL clear_swept got=%h exp=0", rd_data_b); end
      end
      if (k == 10) begin
        total++; if (wr_drop !== 1'b1) begin bad++; $display("FAIL clear_drop_pulse got=%b exp=1", wr_drop); end
      end
      k++;
    end
    total++; if (k !== 32) begin bad++; $display("FAIL clear_duration got=%0d exp=32", k); end
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i), 1'b0);
      cycle();
      total++;
      if (rd_data_a !== 32'd0 || rd_data_b !== 32'd0) begin
        bad++;
        $display("FAIL clear_result addr=%0d got_a=%h got_b=%h exp=0", i, rd_data_a, rd_data_b);
      end
    end
  endtask

  task automatic test_rst_mid_clear();
    int k;
    fill();
    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1);
    cycle();
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 5'd0, 32'd0, 5'd30, 5'd1, 1'b0);
      cycle();
    end
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 5'd30, 5'd1, 1'b0);
    cycle();
    rst = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    total++; if (rd_data_a !== 32'd0) begin bad++; $display("FAIL rst_mid_rd_a got=%h exp=0", rd_data_a); end
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i), 1'b0);
      cycle();
      total++;
      if (rd_data_a !== 32'd0 || rd_data_b !== 32'd0) begin
        bad++;
        $display("FAIL rst_mid_contents addr=%0d got_a=%h got_b=%h exp=0", i, rd_data_a, rd_data_b);
      end
    end
    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1);
    cycle();
    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0);
    k = 0;
    while (busy === 1'b1 && k < 40) begin
      cycle();
      k++;
    end
    total++; if (k !== 32) begin bad++; $display("FAIL rst_then_clear_duration got=%0d exp=32", k); end
  endtask

  task automatic test_random(input int n, input int clr_odds);
    logic [4:0] wa;
    for (int i = 0; i < n; i++) begin
      wa = 5'($urandom_range(0, 31));
      drive(1'($urandom_range(0, 1)), wa, $urandom,
            ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)),
            (clr_odds > 0) && ($urandom_range(1, clr_odds) == 1));
      cycle();
      total++; if (rd_data_a !== e_a) begin bad++; $display("FAIL rand_rd_a i=%0d got=%h exp=%h", i, rd_data_a, e_a); end
      total++; if (rd_data_b !== e_b) begin bad++; $display("FAIL rand_rd_b i=%0d got=%h exp=%h", i, rd_data_b, e_b); end
      total++; if (busy !== 1'(m_busy)) begin bad++; $display("FAIL rand_busy i=%0d got=%b exp=%b", i, busy, m_busy); end
      total++; if (wr_drop !== e_drop) begin bad++; $display("FAIL rand_wr_drop i=%0d got=%b exp=%b", i, wr_drop, e_drop); end
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0);
    test_reset();
    test_write_read();
    test_zero_reg();
    test_bypass();
    test_random(300, 0);
    test_clear();
    test_rst_mid_clear();
    test_random(600, 24);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
